// File: rtl/data_memory_responder.sv
// Word-addressed data memory responder for CPU load/store traffic.
// One request in flight; fixed access latency, then a one-cycle ack.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        busy_o
);

  localparam int unsigned IW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [7:0] CNT_LOAD =
    8'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

  localparam bit ONE_CYCLE = (LATENCY <= 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  req_t        req_q;
  req_t        req_d;
  req_t        req_in;
  req_t        cur;
  logic        cur_err;
  logic [IW-1:0] cur_idx;
  logic        enter_done;
  logic        commit;
  logic        ack_d;
  logic        err_d;
  logic [31:0] rdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_in = {we_i, addr_i, wdata_i};

  // With a one-cycle latency the check runs on the
  // accepting edge, before anything is latched.
  assign cur = (state_q == IDLE) ? req_in : req_q;

  assign cur_err = (|cur.addr[1:0]) ||
                   ({2'b00, cur.addr[31:2]} >= DEPTH_W);

  assign cur_idx = cur.addr[IW+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    enter_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          req_d = req_in;
          if (ONE_CYCLE) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ack_d   = enter_done;
    err_d   = enter_done & cur_err;
    rdata_d = '0;
    if (enter_done && !cur.we && !cur_err) begin
      rdata_d = mem[cur_idx];
    end
  end

  assign commit = enter_done & cur.we & ~cur_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ack_o   <= ack_d;
      err_o   <= err_d;
      rdata_o <= rdata_d;
    end
  end

  // Storage survives reset; a held reset blocks the commit.
  always_ff @(posedge clk_i) begin
    if (commit && rst_i) begin
      mem[cur_idx] <= cur.wdata;
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: vector table plus scoreboard,
// with hand sequences for reset abort, held request and LATENCY=1.
module tb_data_memory_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        ack, err, busy;
  logic [31:0] rdata;
  logic        req1, we1;
  logic [31:0] addr1, wdata1;
  logic        ack1, err1, busy1;
  logic [31:0] rdata1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    string       name;
  } exp_t;

  vec_t vecs[12];
  exp_t sbq[$];

  data_memory_responder #(
    .DEPTH_WORDS(256),
    .LATENCY(LAT)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .req_i(req),
    .we_i(we),
    .addr_i(addr),
    .wdata_i(wdata),
    .ack_o(ack),
    .err_o(err),
    .rdata_o(rdata),
    .busy_o(busy)
  );

  data_memory_responder #(
    .DEPTH_WORDS(256),
    .LATENCY(1)
  ) u_lat1 (
    .clk_i(clk),
    .rst_i(rst_n),
    .req_i(req1),
    .we_i(we1),
    .addr_i(addr1),
    .wdata_i(wdata1),
    .ack_o(ack1),
    .err_o(err1),
    .rdata_o(rdata1),
    .busy_o(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (ack) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_ack", 32'(sbq.size()), 32'd1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
        check({e.name, "_rdata"}, rdata, e.rdata);
        check({e.name, "_lat"}, 32'(cyc - e.acc),
              32'(LAT - 1));
      end
    end
  end

  task automatic wait_ack(string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = ack;
    end
    if (!seen) check({nm, "_timeout"}, {31'b0, ack}, 32'd1);
  endtask

  task automatic run_req(vec_t v);
    exp_t e;
    @(negedge clk);
    req   = 1'b1;
    we    = v.we;
    addr  = v.addr;
    wdata = v.wdata;
    @(posedge clk);
    #1;
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    e.acc   = cyc;
    e.name  = v.name;
    sbq.push_back(e);
    check({v.name, "_busy"}, {31'b0, busy}, 32'd1);
    wait_ack(v.name);
    req = 1'b0;
    @(negedge clk);
    check({v.name, "_pulse"}, {31'b0, ack}, 32'd0);
    check({v.name, "_idle"}, {31'b0, busy}, 32'd0);
    check({v.name, "_rclr"}, rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n;
    exp_t e;
    vec_t v;

    vecs[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0, "w10"};
    vecs[1]  = '{1'b0, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF, "r10"};
    vecs[2]  = '{1'b1, 32'h000, 32'h11111111, 1'b0, 32'h0, "w00"};
    vecs[3]  = '{1'b0, 32'h013, 32'h0, 1'b1, 32'h0, "r13_mis"};
    vecs[4]  = '{1'b0, 32'h400, 32'h0, 1'b1, 32'h0, "r400_oor"};
    vecs[5]  = '{1'b1, 32'h400, 32'hBAD, 1'b1, 32'h0, "w400_oor"};
    vecs[6]  = '{1'b0, 32'h000, 32'h0, 1'b0, 32'h11111111, "r00"};
    vecs[7]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0, "w3fc"};
    vecs[8]  = '{1'b0, 32'h3FC, 32'h0, 1'b0, 32'hCAFEF00D, "r3fc"};
    vecs[9]  = '{1'b1, 32'h020, 32'h5555AAAA, 1'b0, 32'h0, "w20"};
    vecs[10] = '{1'b0, 32'h020, 32'h0, 1'b0, 32'h5555AAAA, "r20"};
    vecs[11] = '{1'b0, 32'h402, 32'h0, 1'b1, 32'h0, "r402_bad"};

    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_busy1", {31'b0, busy1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_req(vecs[i]);

    // Held request: BUSY-time changes ignored, back-to-back accept.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h010; wdata = '0;
    @(posedge clk);
    #1;
    n = cyc;
    e = '{1'b0, 32'hDEADBEEF, n, "held1"};
    sbq.push_back(e);
    we = 1'b1; addr = 32'h3FC; wdata = 32'hFFFFFFFF;
    wait_ack("held1");
    addr = 32'h024; we = 1'b1; wdata = 32'h24242424;
    e = '{1'b0, 32'h0, n + LAT + 1, "held2"};
    sbq.push_back(e);
    @(negedge clk);
    check("held_gap_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("held2_busy", {31'b0, busy}, 32'd1);
    wait_ack("held2");
    req = 1'b0;
    @(negedge clk);
    check("held2_pulse", {31'b0, ack}, 32'd0);
    v = '{1'b0, 32'h3FC, 32'h0, 1'b0, 32'hCAFEF00D, "r3fc_keep"};
    run_req(v);
    v = '{1'b0, 32'h024, 32'h0, 1'b0, 32'h24242424, "r24"};
    run_req(v);

    // Reset during BUSY aborts the write.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h020; wdata = 32'h1234;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rst_busy", {31'b0, busy}, 32'd0);
    check("abort_rst_ack", {31'b0, ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{1'b0, 32'h020, 32'h0, 1'b0, 32'h5555AAAA, "r20_abort"};
    run_req(v);

    // Reset asserted mid-cycle while ack is up.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h010;
    @(posedge clk);
    #1;
    e = '{1'b0, 32'hDEADBEEF, cyc, "r10_rst"};
    sbq.push_back(e);
    wait_ack("r10_rst");
    req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'b0, ack}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LATENCY=1 instance.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0; wdata1 = 32'h77;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    check("l1w_ack", {31'b0, ack1}, 32'd1);
    check("l1w_err", {31'b0, err1}, 32'd0);
    check("l1w_rdata", rdata1, 32'd0);
    check("l1w_busy", {31'b0, busy1}, 32'd1);
    @(posedge clk);
    #1;
    check("l1w_ack_end", {31'b0, ack1}, 32'd0);
    check("l1w_busy_end", {31'b0, busy1}, 32'd0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    check("l1r_ack", {31'b0, ack1}, 32'd1);
    check("l1r_rdata", rdata1, 32'h77);
    check("l1r_busy", {31'b0, busy1}, 32'd1);
    @(posedge clk);
    #1;
    check("l1r_busy_end", {31'b0, busy1}, 32'd0);
    check("l1r_rclr", rdata1, 32'd0);
    req1 = 1'b1; addr1 = 32'h6;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    check("l1e_ack", {31'b0, ack1}, 32'd1);
    check("l1e_err", {31'b0, err1}, 32'd1);
    check("l1e_rdata", rdata1, 32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
